// File: rtl/axi4_master_thread_tracker.sv
// Per-master address-channel qualifier: decodes the target slave and keeps
// a small CAM of open AXI IDs so an ID never targets two slaves at once.
module axi4_master_thread_tracker #(
  parameter int NUM_SLAVES       = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int NUM_THREADS      = 4,
  parameter int OPEN_TRANS_MAX   = 7,
  parameter int OPEN_TRANS_WIDTH = 3,
  parameter int TOTAL_TRANS_MAX  = 16,
  parameter logic [(NUM_SLAVES-1)*ADDR_WIDTH-1:0] SLAVE_BASE_VEC = '0,
  parameter logic [(NUM_SLAVES-1)*ADDR_WIDTH-1:0] SLAVE_MASK_VEC = '0,
  parameter logic [NUM_SLAVES-1:0] CONNECTIVITY = '1
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic [ADDR_WIDTH-1:0]       masterAddr,
  input  logic                        masterValid,
  input  logic [MASTERID_WIDTH-1:0]   masterID,
  output logic                        validQual,
  output logic [NUM_SLAVES_WIDTH-1:0] currTransSlaveID,
  input  logic                        openTransInc,
  input  logic [MASTERID_WIDTH-1:0]   currDataTransID,
  input  logic                        openTransDec,
  input  logic [NUM_SLAVES-1:0]       stopTrans,
  output logic                        threadsFull,
  output logic [$clog2(TOTAL_TRANS_MAX+1)-1:0] openTotal,
  output logic                        protoErr
);

  localparam int TW   = $clog2(TOTAL_TRANS_MAX + 1);
  localparam int IW   = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int DERR = NUM_SLAVES - 1;

  logic [NUM_THREADS-1:0]      vld;
  logic [MASTERID_WIDTH-1:0]   tid  [NUM_THREADS];
  logic [NUM_SLAVES_WIDTH-1:0] tslv [NUM_THREADS];
  logic [OPEN_TRANS_WIDTH-1:0] tcnt [NUM_THREADS];

  logic                        hit;
  logic [NUM_SLAVES_WIDTH-1:0] hit_idx;
  logic [ADDR_WIDTH-1:0]       mask_s;
  logic [ADDR_WIDTH-1:0]       base_s;

  // Scan downward so the lowest hitting slave is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    mask_s  = '0;
    base_s  = '0;
    for (int s = NUM_SLAVES - 2; s >= 0; s--) begin
      mask_s = SLAVE_MASK_VEC[s*ADDR_WIDTH +: ADDR_WIDTH];
      base_s = SLAVE_BASE_VEC[s*ADDR_WIDTH +: ADDR_WIDTH];
      if ((masterAddr & mask_s) == (base_s & mask_s)) begin
        hit     = 1'b1;
        hit_idx = NUM_SLAVES_WIDTH'(s);
      end
    end
  end

  assign currTransSlaveID =
    (hit && CONNECTIVITY[hit_idx]) ? hit_idx
                                   : NUM_SLAVES_WIDTH'(DERR);

  logic          inc_hit;
  logic [IW-1:0] inc_idx;
  logic          dec_hit;
  logic [IW-1:0] dec_idx;
  logic          free_hit;
  logic [IW-1:0] free_idx;

  always_comb begin
    inc_hit  = 1'b0;
    inc_idx  = '0;
    dec_hit  = 1'b0;
    dec_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (vld[i] && tid[i] == masterID) begin
        inc_hit = 1'b1;
        inc_idx = IW'(i);
      end
      if (vld[i] && tid[i] == currDataTransID) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
      end
      if (!vld[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  logic thread_ok;
  logic total_ok;

  always_comb begin
    thread_ok = free_hit;
    if (inc_hit) begin
      thread_ok = (tslv[inc_idx] == currTransSlaveID) &&
                  (tcnt[inc_idx] <
                   OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX));
    end
  end

  assign total_ok  = openTotal < TW'(TOTAL_TRANS_MAX);
  assign validQual = masterValid &&
                     !stopTrans[currTransSlaveID] &&
                     total_ok && thread_ok;

  logic inc_ok;
  logic dec_ok;
  logic same;
  logic alloc;
  logic inc_err;
  logic dec_err;

  assign inc_ok  = openTransInc && validQual;
  assign dec_ok  = openTransDec && dec_hit;
  assign same    = inc_ok && inc_hit && dec_ok &&
                   (inc_idx == dec_idx);
  assign alloc   = inc_ok && !inc_hit;
  assign inc_err = openTransInc && !validQual;
  assign dec_err = openTransDec && !dec_hit;

  assign threadsFull = &vld;

  // An inc and dec on the same entry cancel, so that entry is left alone.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      vld <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        tid[i]  <= '0;
        tslv[i] <= '0;
        tcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (!same) begin
          if (inc_ok && inc_hit && inc_idx == IW'(i)) begin
            tcnt[i] <= tcnt[i] + 1'b1;
          end
          if (dec_ok && dec_idx == IW'(i)) begin
            tcnt[i] <= tcnt[i] - 1'b1;
            if (tcnt[i] == OPEN_TRANS_WIDTH'(1)) begin
              vld[i] <= 1'b0;
            end
          end
          if (alloc && free_idx == IW'(i)) begin
            vld[i]  <= 1'b1;
            tid[i]  <= masterID;
            tslv[i] <= currTransSlaveID;
            tcnt[i] <= OPEN_TRANS_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      openTotal <= '0;
      protoErr  <= 1'b0;
    end else begin
      unique case (1'b1)
        (inc_ok && !dec_ok): openTotal <= openTotal + 1'b1;
        (dec_ok && !inc_ok): openTotal <= openTotal - 1'b1;
        default:             openTotal <= openTotal;
      endcase
      protoErr <= protoErr | inc_err | dec_err;
    end
  end

endmodule

// File: tb/tb_axi4_master_thread_tracker.sv
// Directed bench for axi4_master_thread_tracker with an ID-keyed
// reference model and a per-cycle compare on the falling edge.
module tb_axi4_master_thread_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        mv;
  logic [3:0]  mid;
  logic        inc;
  logic [3:0]  did;
  logic        dec;
  logic [2:0]  stop;

  logic       vq;
  logic [1:0] slv;
  logic       full;
  logic [4:0] tot;
  logic       err;

  logic       nc_vq;
  logic [1:0] nc_slv;
  logic       nc_full;
  logic [4:0] nc_tot;
  logic       nc_err;

  localparam logic [63:0] BASES = {32'h1000_0000, 32'h0000_0000};
  localparam logic [63:0] MASKS = {32'hF000_0000, 32'hF000_0000};

  always #5 clk = ~clk;

  axi4_master_thread_tracker #(
    .NUM_SLAVES(3), .NUM_SLAVES_WIDTH(2), .MASTERID_WIDTH(4),
    .ADDR_WIDTH(32), .NUM_THREADS(4), .OPEN_TRANS_MAX(7),
    .OPEN_TRANS_WIDTH(3), .TOTAL_TRANS_MAX(16),
    .SLAVE_BASE_VEC(BASES), .SLAVE_MASK_VEC(MASKS),
    .CONNECTIVITY(3'b111)
  ) dut (
    .sysClk(clk), .sysReset(rst), .masterAddr(addr),
    .masterValid(mv), .masterID(mid), .validQual(vq),
    .currTransSlaveID(slv), .openTransInc(inc),
    .currDataTransID(did), .openTransDec(dec),
    .stopTrans(stop), .threadsFull(full),
    .openTotal(tot), .protoErr(err)
  );

  // Same map, slave 0 unreachable: only its decode is observed.
  axi4_master_thread_tracker #(
    .NUM_SLAVES(3), .NUM_SLAVES_WIDTH(2), .MASTERID_WIDTH(4),
    .ADDR_WIDTH(32), .NUM_THREADS(4), .OPEN_TRANS_MAX(7),
    .OPEN_TRANS_WIDTH(3), .TOTAL_TRANS_MAX(16),
    .SLAVE_BASE_VEC(BASES), .SLAVE_MASK_VEC(MASKS),
    .CONNECTIVITY(3'b110)
  ) dut_nc (
    .sysClk(clk), .sysReset(rst), .masterAddr(addr),
    .masterValid(mv), .masterID(mid), .validQual(nc_vq),
    .currTransSlaveID(nc_slv), .openTransInc(inc),
    .currDataTransID(did), .openTransDec(dec),
    .stopTrans(stop), .threadsFull(nc_full),
    .openTotal(nc_tot), .protoErr(nc_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  int cnt_of [int];
  int slv_of [int];
  int m_total;
  bit m_err;

  function automatic int m_dec(input logic [31:0] a,
                               input logic [2:0] conn);
    int s;
    s = 2;
    if (a[31:28] == 4'h0) s = 0;
    else if (a[31:28] == 4'h1) s = 1;
    if (s != 2 && !conn[s]) s = 2;
    return s;
  endfunction

  function automatic bit m_qual();
    int s;
    bit ok;
    s = m_dec(addr, 3'b111);
    if (cnt_of.exists(int'(mid)))
      ok = slv_of[int'(mid)] == s && cnt_of[int'(mid)] < 7;
    else
      ok = cnt_of.num() < 4;
    return mv && !stop[s] && m_total < 16 && ok;
  endfunction

  always @(posedge clk) begin
    bit q;
    bit dok;
    if (rst) begin
      cnt_of.delete();
      slv_of.delete();
      m_total = 0;
      m_err   = 1'b0;
    end else begin
      q   = m_qual();
      dok = dec && cnt_of.exists(int'(did));
      if (inc && !q) m_err = 1'b1;
      if (dec && !dok) m_err = 1'b1;
      if (inc && q) begin
        if (cnt_of.exists(int'(mid))) begin
          cnt_of[int'(mid)] = cnt_of[int'(mid)] + 1;
        end else begin
          cnt_of[int'(mid)] = 1;
          slv_of[int'(mid)] = m_dec(addr, 3'b111);
        end
        m_total++;
      end
      if (dok) begin
        cnt_of[int'(did)] = cnt_of[int'(did)] - 1;
        if (cnt_of[int'(did)] == 0) begin
          cnt_of.delete(int'(did));
          slv_of.delete(int'(did));
        end
        m_total--;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("model_vq", int'(vq), int'(m_qual()));
      chk("model_slv", int'(slv), m_dec(addr, 3'b111));
      chk("model_slv_nc", int'(nc_slv), m_dec(addr, 3'b110));
      chk("model_full", int'(full), int'(cnt_of.num() == 4));
      chk("model_total", int'(tot), m_total);
      chk("model_err", int'(err), int'(m_err));
    end
  end

  task automatic drive(input logic [31:0] a, input logic [3:0] id,
                       input logic v, input logic i,
                       input logic d, input logic [3:0] di,
                       input logic [2:0] st);
    addr = a; mid = id; mv = v; inc = i;
    dec = d; did = di; stop = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    run = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vq", int'(vq), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_total", int'(tot), 0);
    chk("rst_err", int'(err), 0);
    tick();

    drive(32'h0123_4567, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("dec_slv0", int'(slv), 0);
    chk("dec_vq", int'(vq), 1);
    chk("dec_nc_derr", int'(nc_slv), 2);
    tick();

    for (int k = 0; k < 7; k++) begin
      drive(32'h0123_4567, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 3'b000);
      tick();
    end
    drive(32'h0123_4567, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("cnt7_total", int'(tot), 7);
    chk("cnt7_vq", int'(vq), 0);
    tick();

    drive(32'h0123_4567, 4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 3'b000);
    tick();
    drive(32'h0123_4567, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("dec1_vq", int'(vq), 1);
    chk("dec1_total", int'(tot), 6);
    tick();

    drive(32'h1000_0040, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("order_slv1", int'(slv), 1);
    chk("order_vq", int'(vq), 0);
    tick();

    for (int k = 0; k < 6; k++) begin
      drive(32'h1000_0040, 4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 3'b000);
      tick();
    end
    drive(32'h1000_0040, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("freed_vq", int'(vq), 1);
    chk("freed_total", int'(tot), 0);
    drive(32'h1000_0040, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 3'b000);
    tick();
    drive(32'h1000_0040, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("realloc_total", int'(tot), 1);
    chk("realloc_vq_s1", int'(vq), 1);
    drive(32'h0000_0100, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    #1;
    chk("realloc_vq_s0", int'(vq), 0);
    tick();

    drive(32'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 3'b000);
    tick();
    for (int id = 1; id <= 4; id++) begin
      drive(32'h0000_0010, 4'(id), 1'b1, 1'b1, 1'b0, 4'd0, 3'b000);
      tick();
    end
    drive(32'h0000_0010, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("full_flag", int'(full), 1);
    chk("full_vq", int'(vq), 0);
    tick();

    drive(32'h0000_0010, 4'd2, 1'b1, 1'b1, 1'b1, 4'd2, 3'b000);
    tick();
    idle();
    @(negedge clk);
    chk("incdec_total", int'(tot), 4);
    chk("incdec_full", int'(full), 1);
    tick();

    drive(32'h0000_0010, 4'd5, 1'b1, 1'b1, 1'b1, 4'd1, 3'b000);
    @(negedge clk);
    chk("presample_vq", int'(vq), 0);
    tick();
    drive(32'h0000_0010, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("presample_vq2", int'(vq), 1);
    chk("presample_full", int'(full), 0);
    chk("presample_total", int'(tot), 3);
    chk("presample_err", int'(err), 1);
    tick();

    do_reset();
    @(negedge clk);
    chk("rst2_err", int'(err), 0);
    chk("rst2_total", int'(tot), 0);
    chk("rst2_full", int'(full), 0);
    tick();

    for (int id = 1; id <= 4; id++) begin
      for (int k = 0; k < 4; k++) begin
        drive(32'h0000_0020, 4'(id), 1'b1, 1'b1, 1'b0, 4'd0, 3'b000);
        tick();
      end
    end
    drive(32'h0000_0020, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000);
    @(negedge clk);
    chk("limit_total", int'(tot), 16);
    chk("limit_vq", int'(vq), 0);
    tick();
    do_reset();

    drive(32'h0000_0020, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 3'b001);
    @(negedge clk);
    chk("stop_vq", int'(vq), 0);
    tick();
    drive(32'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 3'b000);
    tick();
    idle();
    @(negedge clk);
    chk("bad_dec_err", int'(err), 1);
    chk("bad_dec_total", int'(tot), 0);
    tick();

    do_reset();
    @(negedge clk);
    chk("rst3_err", int'(err), 0);
    chk("rst3_total", int'(tot), 0);
    chk("rst3_full", int'(full), 0);
    tick();

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
